// File: rtl/mem_axis_dma_ctrl.sv
// mem_axis_dma_ctrl: memory-to-AXI-Stream DMA that packs bytes little-endian into 32-bit beats
// Ports:
//   clk, rst (async, active-low)
//   start/src_addr/byte_len -> command in; busy/done -> status out
//   host_req/host_addr/host_wdata/host_we -> host requester; host_gnt/host_rdata/host_rvalid -> host response
//   mem_addr/mem_wdata/mem_we/mem_re -> byte-wide memory port; mem_rdata valid the cycle after mem_re
//   m00_axis_* -> 32-bit AXI-Stream master with tstrb and tlast
module mem_axis_dma_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH = 16,
  parameter int C_AXIS_TDATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           src_addr,
  input  logic [LEN_WIDTH-1:0]            byte_len,
  output logic                            busy,
  output logic                            done,
  input  logic                            host_req,
  input  logic [ADDR_WIDTH-1:0]           host_addr,
  input  logic [7:0]                      host_wdata,
  input  logic                            host_we,
  output logic                            host_gnt,
  output logic [7:0]                      host_rdata,
  output logic                            host_rvalid,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [7:0]                      mem_wdata,
  output logic                            mem_we,
  output logic                            mem_re,
  input  logic [7:0]                      mem_rdata,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                            m00_axis_tvalid,
  input  logic                            m00_axis_tready,
  output logic                            m00_axis_tlast
);
  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0] remaining;
  logic [2:0] issued;
  logic [1:0] pend_lane;
  logic pend, pend_last, last_host, dma_req, dma_gnt, hs;
  // DMA asks for the port only while the current beat still has reads to issue
  assign dma_req = state == FETCH && issued != 3'd4 && remaining != '0;
  // On contention the previous contended loser wins; last_host resets low so the host wins first
  assign host_gnt = rst && host_req && (!dma_req || !last_host);
  assign dma_gnt = dma_req && !host_gnt;
  assign mem_addr = host_gnt ? host_addr : dma_gnt ? cur_addr : '0;
  assign mem_wdata = host_gnt ? host_wdata : '0;
  assign mem_we = host_gnt && host_we;
  assign mem_re = host_gnt ? !host_we : dma_gnt;
  assign host_rdata = mem_rdata;
  assign hs = m00_axis_tvalid && m00_axis_tready;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = byte_len == '0 ? DONE : FETCH;
      FETCH: if (pend && pend_last) state_nx = SEND;
      SEND:  if (hs) state_nx = m00_axis_tlast ? DONE : FETCH;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      host_rvalid <= 1'b0;
      last_host <= 1'b0;
      cur_addr <= '0;
      remaining <= '0;
      issued <= '0;
      pend <= 1'b0;
      pend_last <= 1'b0;
      pend_lane <= '0;
      m00_axis_tdata <= '0;
      m00_axis_tstrb <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast <= 1'b0;
    end else begin
      if (host_req && dma_req) last_host <= host_gnt;
      host_rvalid <= host_gnt && !host_we;
      done <= state == DONE;
      pend <= dma_gnt;
      if (state == IDLE && start) begin
        busy <= 1'b1;
        cur_addr <= src_addr;
        remaining <= byte_len;
        issued <= '0;
      end
      if (state == DONE) busy <= 1'b0;
      if (dma_gnt) begin
        cur_addr <= cur_addr + 1'b1;
        remaining <= remaining - 1'b1;
        issued <= issued + 3'd1;
        pend_lane <= issued[1:0];
        pend_last <= issued == 3'd3 || remaining == LEN_WIDTH'(1);
      end
      if (pend) m00_axis_tdata[pend_lane*8 +: 8] <= mem_rdata;
      // Lanes above the final byte are already zero: tdata is cleared after every accepted beat
      if (pend && pend_last) begin
        m00_axis_tvalid <= 1'b1;
        m00_axis_tstrb <= 4'hF >> (2'd3 - pend_lane);
        m00_axis_tlast <= remaining == '0;
      end
      if (hs) begin
        m00_axis_tvalid <= 1'b0;
        m00_axis_tlast <= 1'b0;
        m00_axis_tstrb <= '0;
        m00_axis_tdata <= '0;
        issued <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_axis_dma_ctrl.sv
// tb_mem_axis_dma_ctrl: scoreboard bench for the memory-to-stream DMA with a byte memory model
module tb_mem_axis_dma_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic start = 1'b0, busy, done;
  logic [15:0] src_addr = '0, byte_len = '0;
  logic host_req = 1'b0, host_we = 1'b0, host_gnt, host_rvalid;
  logic [15:0] host_addr = '0;
  logic [7:0] host_wdata = '0, host_rdata;
  logic [15:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata = '0;
  logic mem_we, mem_re;
  logic [31:0] tdata;
  logic [3:0] tstrb;
  logic tvalid, tlast, tready = 1'b1;
  logic [7:0] mem [0:65535];
  logic [36:0] exp_q [$];
  logic [36:0] e;
  int checks = 0, errors = 0;
  int done_cnt = 0, dma_rd = 0, host_dbl = 0, dma_dbl = 0, rv_bad = 0, host_run = 0, hg = 0;
  logic prev_rd = 1'b0, prev_dma = 1'b0, dma_now;

  mem_axis_dma_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .byte_len(byte_len),
    .busy(busy), .done(done), .host_req(host_req), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_we(host_we), .host_gnt(host_gnt),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .m00_axis_tdata(tdata), .m00_axis_tstrb(tstrb), .m00_axis_tvalid(tvalid),
    .m00_axis_tready(tready), .m00_axis_tlast(tlast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and tracks arbitration statistics
  always @(negedge clk) begin
    if (!rst) begin
      prev_rd = 1'b0;
      prev_dma = 1'b0;
      host_run = 0;
    end else begin
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat got %h/%h/%b want none", tdata, tstrb, tlast);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {27'd0, tdata, tstrb, tlast}, {27'd0, e});
        end
      end
      if (done) done_cnt++;
      if (host_rvalid !== prev_rd) rv_bad++;
      prev_rd = host_gnt && !host_we;
      if (host_gnt) hg++;
      dma_now = mem_re && !host_gnt;
      if (dma_now) dma_rd++;
      if (host_req && !host_gnt) begin
        host_run++;
        if (host_run > 1) host_dbl++;
      end else host_run = 0;
      if (host_req && dma_now && prev_dma) dma_dbl++;
      prev_dma = dma_now;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hwr(input logic [15:0] a, input logic [7:0] d);
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = a;
    host_wdata = d;
    tick();
    host_req = 1'b0;
    host_we = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] s, input logic l);
    exp_q.push_back({d, s, l});
  endtask

  task automatic go(input logic [15:0] a, input logic [15:0] l);
    src_addr = a;
    byte_len = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    logic seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk(nm, {63'd0, seen}, 64'd1);
    tick();
  endtask

  task automatic wait_tvalid(input int budget, input string nm);
    logic seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = tvalid;
    end
    chk(nm, {63'd0, seen}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int d0, dr, hd, dd, rb, h0, bad, re_seen;
    logic [7:0] blk [5];
    blk = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {56'd0, busy, done, tvalid, tlast, host_rvalid, mem_we, mem_re, host_gnt}, 64'd0);
    chk("reset_data", {4'd0, tdata, tstrb, mem_addr, mem_wdata}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    // 1: host-written block, two full beats
    for (int i = 0; i < 8; i++) hwr(16'h0100 + 16'(i), 8'(8'h11 * (i + 1)));
    host_req = 1'b1;
    host_addr = 16'h0103;
    tick();
    host_req = 1'b0;
    @(negedge clk);
    chk("host_read", {55'd0, host_rvalid, host_rdata}, {55'd0, 1'b1, 8'h44});
    tick();
    push(32'h44332211, 4'hF, 1'b0);
    push(32'h88776655, 4'hF, 1'b1);
    d0 = done_cnt;
    go(16'h0100, 16'd8);
    chk("s1_busy", {63'd0, busy}, 64'd1);
    wait_done(100, "s1_done");
    repeat (3) tick();
    chk("s1_done_once", 64'(done_cnt - d0), 64'd1);
    chk("s1_busy_low", {63'd0, busy}, 64'd0);
    chk("s1_q_empty", 64'(exp_q.size()), 64'd0);
    // 2: odd length, partial last beat
    for (int i = 0; i < 5; i++) hwr(16'h0200 + 16'(i), blk[i]);
    push(32'hDDCCBBAA, 4'hF, 1'b0);
    push(32'h000000EE, 4'h1, 1'b1);
    go(16'h0200, 16'd5);
    wait_done(100, "s2_done");
    chk("s2_q_empty", 64'(exp_q.size()), 64'd0);
    // 3: backpressure on the first beat
    tready = 1'b0;
    push(32'h44332211, 4'hF, 1'b0);
    push(32'h88776655, 4'hF, 1'b1);
    go(16'h0100, 16'd8);
    wait_tvalid(50, "s3_tvalid");
    bad = 0;
    re_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(tvalid && tdata == 32'h44332211 && tstrb == 4'hF && !tlast)) bad++;
      if (mem_re) re_seen++;
    end
    chk("s3_stable", 64'(bad), 64'd0);
    chk("s3_no_re", 64'(re_seen), 64'd0);
    tick();
    tready = 1'b1;
    @(posedge clk);
    #1 chk("s3_accepted", {63'd0, tvalid}, 64'd0);
    wait_done(100, "s3_done");
    chk("s3_q_empty", 64'(exp_q.size()), 64'd0);
    // 4: host reading every cycle during the transfer
    dr = dma_rd;
    hd = host_dbl;
    dd = dma_dbl;
    rb = rv_bad;
    h0 = hg;
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = 16'h0100;
    push(32'h44332211, 4'hF, 1'b0);
    push(32'h88776655, 4'hF, 1'b1);
    go(16'h0100, 16'd8);
    wait_done(200, "s4_done");
    host_req = 1'b0;
    tick();
    chk("s4_dma_reads", 64'(dma_rd - dr), 64'd8);
    chk("s4_host_alt", 64'(host_dbl - hd), 64'd0);
    chk("s4_dma_alt", 64'(dma_dbl - dd), 64'd0);
    chk("s4_rvalid", 64'(rv_bad - rb), 64'd0);
    chk("s4_host_gnts", {63'd0, (hg - h0) >= 8}, 64'd1);
    chk("s4_q_empty", 64'(exp_q.size()), 64'd0);
    // 5: zero length, then address wrap
    go(16'h0000, 16'd0);
    @(negedge clk);
    chk("s5_done_early", {63'd0, done}, 64'd0);
    @(negedge clk);
    chk("s5_done_pulse", {62'd0, done, tvalid}, 64'd2);
    @(negedge clk);
    chk("s5_done_1cyc", {62'd0, done, busy}, 64'd0);
    tick();
    for (int i = 0; i < 4; i++) hwr(16'(16'hFFFE + 16'(i)), 8'(i + 1));
    push(32'h04030201, 4'hF, 1'b1);
    go(16'hFFFE, 16'd4);
    wait_done(100, "s5_wrap_done");
    chk("s5_q_empty", 64'(exp_q.size()), 64'd0);
    // 6: asynchronous reset while a beat is presented
    tready = 1'b0;
    go(16'h0100, 16'd8);
    wait_tvalid(50, "s6_tvalid");
    d0 = done_cnt;
    #2 rst = 1'b0;
    #1;
    chk("s6_async_ctrl", {57'd0, busy, done, tvalid, tlast, host_rvalid, mem_we, mem_re}, 64'd0);
    chk("s6_async_data", {12'd0, tdata, tstrb, mem_addr}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tready = 1'b1;
    repeat (3) tick();
    chk("s6_no_done", 64'(done_cnt - d0), 64'd0);
    push(32'hDDCCBBAA, 4'hF, 1'b1);
    go(16'h0200, 16'd4);
    wait_done(100, "s6_done");
    chk("s6_done_once", 64'(done_cnt - d0), 64'd1);
    chk("s6_q_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
